dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter in front of the data memory, sharing its single access port between the core load/store unit (port C) and the debug/loader port (port D). Arbitrates valid/ready requests, drives the memory address/write-data/write-strobe, and returns registered read data plus an error flag one cycle after acceptance. Supports a locked sequence (read-modify-write) so one requester can hold the memory across several accesses.

## Interface
Parameters:
- ADDR_LIMIT, 1024, byte size of the memory; accesses with addr >= ADDR_LIMIT are errors

Ports (x = c for core, d for debug; each x port set is identical):
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- x_req_valid  in  1  request present; payload held stable until accepted
- x_req_ready  out  1  request accepted this cycle
- x_req_addr  in  u32_t  byte address, word-aligned use only (bits [1:0] ignored)
- x_req_wrdata  in  u32_t  write data
- x_req_wrstb  in  wrstb_t  byte write strobes; all zero = read
- x_req_lock  in  1  keep grant after this access
- x_rsp_valid  out  1  one-cycle response pulse
- x_rsp_rddata  out  u32_t  word read at acceptance (pre-write contents)
- x_rsp_err  out  1  out-of-range access
- m_addr  out  u32_t  to memory address
- m_wrdata  out  u32_t  to memory write data
- m_wrstb  out  wrstb_t  to memory write strobes
- m_rddata  in  u32_t  from memory, combinational read

## Operation
- States: ARB, LOCK_C, LOCK_D. Reset state ARB.
- ARB: grant chosen combinationally among valid ports (policy per Configuration). LOCK_C: only C may be granted; D ready held 0. LOCK_D symmetric.
- x_req_ready = grant to x; never asserted without x_req_valid. At most one ready high per cycle.
- Granted port drives m_addr/m_wrdata; m_wrstb = x_req_wrstb if addr < ADDR_LIMIT, else 0. No grant: m_addr = 0, m_wrdata = 0, m_wrstb = 0.
- Acceptance edge: memory write commits; m_rddata captured into x response register; x_rsp_err = (addr >= ADDR_LIMIT); on error rddata captured as 0.
- Lock transitions: accept with lock=1 in ARB -> LOCK_x; accept with lock=0 in LOCK_x -> ARB; lock=1 in LOCK_x stays. Lock on errored access still honoured.
- Responses unconditional (no backpressure); requester must take rsp on the pulse.
- Reset values: x_req_ready 0, x_rsp_valid 0, x_rsp_rddata 0, x_rsp_err 0, m_* 0, last-grant register = D.
- Reset mid-lock or mid-response: returns to ARB, pending response pulse dropped.

## Timing
- Request accepted in cycle N (valid & ready at edge N); x_rsp_valid high for exactly cycle N+1.
- Back-to-back accepts allowed every cycle from either port; throughput one access/cycle.
- Read data is read-before-write: a write and read-back issued by same port in cycles N, N+1 returns new data at N+2.
- Zero-cycle ready: ready is combinational from valid and state.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin in ARB; on C/D conflict, grant the port not granted last; last-grant register updates on every accept.
- Undefined: fixed priority, C always wins conflicts in ARB; last-grant register absent. Lock behaviour identical in both.

## Structure
- Shared types package: arb_state_t enum (ARB, LOCK_C, LOCK_D), port_id_t (PORT_C, PORT_D), rsp_t struct (valid, rddata, err).
- Sub-module dmem_arb_rsp: per-port response register (capture on accept, clear next cycle, async reset), instantiated twice.

## Test plan
- Reset: assert rst_n=0 with both valid -> all readies 0, rsp outputs 0, m_wrstb 0.
- C write addr 0x10 data 0xDEADBEEF wrstb 4'b1111, then C read 0x10 -> second rsp_rddata 0xDEADBEEF, rsp_err 0.
- Both valid continuously, DMEM_ARB_RR_EN defined -> grants C,D,C,D; undefined -> C every cycle, D starved.
- C read 0x20 lock=1, D valid, C write 0x20 lock=0 -> D ready 0 for both C accesses, D accepted next cycle.
- D write 0x400 (ADDR_LIMIT=1024) -> m_wrstb 0, d_rsp_err 1, d_rsp_rddata 0.
- rst_n pulled low while in LOCK_C -> state ARB after release, D granted on next valid.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Round-robin arbitration is enabled with DMEM_ARB_RR_EN.
package dmem_arbiter_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;

  typedef enum logic [1:0] {
    ARB,
    LOCK_C,
    LOCK_D
  } arb_state_t;

  typedef enum logic {
    PORT_C,
    PORT_D
  } port_id_t;

  typedef struct packed {
    logic valid;
    u32_t rddata;
    logic err;
  } rsp_t;

  function automatic logic in_range(
    input u32_t addr,
    input u32_t limit
  );
    return addr < limit;
  endfunction

endpackage

// File: rtl/dmem_arb_rsp.sv
// Per-port response register: one-cycle pulse after acceptance.
// Errored accesses return zero read data.
module dmem_arb_rsp
  import dmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cap,
  input  u32_t rddata,
  input  logic err,
  output rsp_t rsp
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp <= '0;
    end else if (cap) begin
      rsp.valid  <= 1'b1;
      rsp.rddata <= err ? '0 : rddata;
      rsp.err    <= err;
    end else begin
      rsp <= '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core/debug) arbiter for the single data-memory port.
// Define DMEM_ARB_RR_EN for round-robin; default is fixed C priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   c_req_valid,
  output logic   c_req_ready,
  input  u32_t   c_req_addr,
  input  u32_t   c_req_wrdata,
  input  wrstb_t c_req_wrstb,
  input  logic   c_req_lock,
  output logic   c_rsp_valid,
  output u32_t   c_rsp_rddata,
  output logic   c_rsp_err,
  input  logic   d_req_valid,
  output logic   d_req_ready,
  input  u32_t   d_req_addr,
  input  u32_t   d_req_wrdata,
  input  wrstb_t d_req_wrstb,
  input  logic   d_req_lock,
  output logic   d_rsp_valid,
  output u32_t   d_rsp_rddata,
  output logic   d_rsp_err,
  output u32_t   m_addr,
  output u32_t   m_wrdata,
  output wrstb_t m_wrstb,
  input  u32_t   m_rddata
);

  localparam u32_t LIMIT = u32_t'(ADDR_LIMIT);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       gnt_c;
  logic       gnt_d;
  logic       c_ok;
  logic       d_ok;
  logic       prefer_d;
  rsp_t       c_rsp;
  rsp_t       d_rsp;

  assign c_ok = in_range(c_req_addr, LIMIT);
  assign d_ok = in_range(d_req_addr, LIMIT);

`ifdef DMEM_ARB_RR_EN
  port_id_t last_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= PORT_D;
    end else if (gnt_c) begin
      last_gnt <= PORT_C;
    end else if (gnt_d) begin
      last_gnt <= PORT_D;
    end
  end

  assign prefer_d = (last_gnt == PORT_C);
`else
  assign prefer_d = 1'b0;
`endif

  // Ready is gated by reset so nothing is granted while rst_n is low.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (rst_n) begin
      unique case (state)
        ARB: begin
          if (c_req_valid && d_req_valid) begin
            gnt_c = !prefer_d;
            gnt_d = prefer_d;
          end else begin
            gnt_c = c_req_valid;
            gnt_d = d_req_valid;
          end
        end
        LOCK_C: gnt_c = c_req_valid;
        LOCK_D: gnt_d = d_req_valid;
        default: ;
      endcase
    end
  end

  assign c_req_ready = gnt_c;
  assign d_req_ready = gnt_d;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      gnt_c:   state_nxt = c_req_lock ? LOCK_C : ARB;
      gnt_d:   state_nxt = d_req_lock ? LOCK_D : ARB;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    m_addr   = '0;
    m_wrdata = '0;
    m_wrstb  = '0;
    unique case (1'b1)
      gnt_c: begin
        m_addr   = c_req_addr;
        m_wrdata = c_req_wrdata;
        m_wrstb  = c_ok ? c_req_wrstb : '0;
      end
      gnt_d: begin
        m_addr   = d_req_addr;
        m_wrdata = d_req_wrdata;
        m_wrstb  = d_ok ? d_req_wrstb : '0;
      end
      default: ;
    endcase
  end

  dmem_arb_rsp u_c_rsp (
    .clk    (clk),
    .rst_n  (rst_n),
    .cap    (gnt_c),
    .rddata (m_rddata),
    .err    (!c_ok),
    .rsp    (c_rsp)
  );

  dmem_arb_rsp u_d_rsp (
    .clk    (clk),
    .rst_n  (rst_n),
    .cap    (gnt_d),
    .rddata (m_rddata),
    .err    (!d_ok),
    .rsp    (d_rsp)
  );

  assign c_rsp_valid  = c_rsp.valid;
  assign c_rsp_rddata = c_rsp.rddata;
  assign c_rsp_err    = c_rsp.err;
  assign d_rsp_valid  = d_rsp.valid;
  assign d_rsp_rddata = d_rsp.rddata;
  assign d_rsp_err    = d_rsp.err;

endmodule
